// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment search, control/TERC4 classification
// and video byte decode for one channel of a parallel deserializer.
module tmds_channel_decoder #(
    parameter int unsigned N_LOCK       = 8,
    parameter int unsigned LOSS_TIMEOUT = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds_raw,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic       is_terc4,
    output logic [3:0] terc4,
    output logic [7:0] data,
    output logic       de
);

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    localparam logic [7:0]  RUN_LAST = 8'(N_LOCK - 1);
    // Drop happens on the non-control symbol that brings the count to LOSS_TIMEOUT-1.
    localparam logic [15:0] WD_LAST  = 16'(LOSS_TIMEOUT - 2);

    state_e      state_q, state_d;
    logic [9:0]  prev_q;
    logic [3:0]  offset_q, offset_d;
    logic [7:0]  run_q, run_d;
    logic [15:0] wd_q, wd_d;
    logic        locked_q, locked_d;
    logic        is_ctrl_q, is_terc4_q, de_q;
    logic [1:0]  ctrl_q;
    logic [3:0]  terc4_q;
    logic [7:0]  data_q;

    logic [19:0] cat, cat_sh;
    logic [9:0]  win;
    logic [3:0]  off_inc;
    logic        tok_hit, terc_hit;
    logic [1:0]  tok_val;
    logic [3:0]  terc_val;
    logic [7:0]  d_inv, vid;

    assign cat     = {tmds_raw, prev_q};
    assign cat_sh  = cat >> offset_q;
    assign win     = cat_sh[9:0];
    assign off_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        tok_hit = 1'b0;
        tok_val = 2'b00;
        case (win)
            10'b1101010100: begin tok_hit = 1'b1; tok_val = 2'b00; end
            10'b0010101011: begin tok_hit = 1'b1; tok_val = 2'b01; end
            10'b0101010100: begin tok_hit = 1'b1; tok_val = 2'b10; end
            10'b1010101011: begin tok_hit = 1'b1; tok_val = 2'b11; end
            default: ;
        endcase
    end

    always_comb begin
        terc_hit = 1'b1;
        terc_val = 4'h0;
        case (win)
            10'b1010011100: terc_val = 4'h0;
            10'b1001100011: terc_val = 4'h1;
            10'b1011100100: terc_val = 4'h2;
            10'b1011100010: terc_val = 4'h3;
            10'b0101110001: terc_val = 4'h4;
            10'b0100011110: terc_val = 4'h5;
            10'b0110001110: terc_val = 4'h6;
            10'b0100111100: terc_val = 4'h7;
            10'b1011001100: terc_val = 4'h8;
            10'b0100111001: terc_val = 4'h9;
            10'b0110011100: terc_val = 4'hA;
            10'b1011000110: terc_val = 4'hB;
            10'b1010001110: terc_val = 4'hC;
            10'b1001110001: terc_val = 4'hD;
            10'b0101100011: terc_val = 4'hE;
            10'b1011000011: terc_val = 4'hF;
            default:        terc_hit = 1'b0;
        endcase
    end

    // Undo the TMDS transition-minimising stage (XOR/XNOR chain).
    always_comb begin
        d_inv  = win[9] ? ~win[7:0] : win[7:0];
        vid    = 8'h00;
        vid[0] = d_inv[0];
        for (int i = 1; i < 8; i++) begin
            vid[i] = win[8] ? (d_inv[i] ^ d_inv[i-1])
                            : ~(d_inv[i] ^ d_inv[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        wd_d     = wd_q;
        locked_d = locked_q;
        case (state_q)
            S_SEARCH: begin
                if (tok_hit) begin
                    if (run_q == RUN_LAST) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                        run_d    = 8'd0;
                        wd_d     = 16'd0;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end else begin
                    run_d    = 8'd0;
                    offset_d = off_inc;
                end
            end
            S_LOCKED: begin
                if (tok_hit) begin
                    wd_d = 16'd0;
                end else if (wd_q == WD_LAST) begin
                    state_d  = S_SEARCH;
                    locked_d = 1'b0;
                    run_d    = 8'd0;
                    wd_d     = 16'd0;
                    offset_d = off_inc;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                state_d  = S_SEARCH;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= S_SEARCH;
            prev_q     <= 10'd0;
            offset_q   <= 4'd0;
            run_q      <= 8'd0;
            wd_q       <= 16'd0;
            locked_q   <= 1'b0;
            is_ctrl_q  <= 1'b0;
            ctrl_q     <= 2'b00;
            is_terc4_q <= 1'b0;
            terc4_q    <= 4'h0;
            data_q     <= 8'h00;
            de_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= tmds_raw;
            offset_q   <= offset_d;
            run_q      <= run_d;
            wd_q       <= wd_d;
            locked_q   <= locked_d;
            is_ctrl_q  <= tok_hit;
            ctrl_q     <= tok_hit ? tok_val : 2'b00;
            is_terc4_q <= terc_hit;
            terc4_q    <= terc_hit ? terc_val : 4'h0;
            data_q     <= vid;
            de_q       <= locked_d & ~tok_hit;
        end
    end

    assign locked     = locked_q;
    assign bit_offset = offset_q;
    assign is_ctrl    = is_ctrl_q;
    assign ctrl       = ctrl_q;
    assign is_terc4   = is_terc4_q;
    assign terc4      = terc4_q;
    assign data       = data_q;
    assign de         = de_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed lock/decode/timeout/reset steps
// plus random words, all checked against a bit-window reference model.
module tb_tmds_channel_decoder;

    localparam int N_LOCK = 8;
    localparam int LOSS_TIMEOUT = 4096;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] V00  = 10'b0100000000;
    localparam logic [9:0] VFE  = 10'b1011111111;
    localparam logic [9:0] T5   = 10'b0100011110;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] tmds_raw = 10'd0;
    logic       locked, is_ctrl, is_terc4, de;
    logic [3:0] bit_offset, terc4;
    logic [1:0] ctrl;
    logic [7:0] data;

    tmds_channel_decoder #(.N_LOCK(N_LOCK), .LOSS_TIMEOUT(LOSS_TIMEOUT)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .tmds_raw  (tmds_raw),
        .locked    (locked),
        .bit_offset(bit_offset),
        .is_ctrl   (is_ctrl),
        .ctrl      (ctrl),
        .is_terc4  (is_terc4),
        .terc4     (terc4),
        .data      (data),
        .de        (de)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [9:0] ctab [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};
    logic [9:0] ttab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    int n_checks = 0;
    int n_err = 0;

    // reference model state
    logic [9:0] m_prev = '0;
    bit         m_locked = 0;
    int         m_off = 0;
    int         m_tokens = 0;
    int         m_misses = 0;
    bit         e_is_ctrl, e_is_terc4, e_de;
    logic [1:0] e_ctrl;
    logic [3:0] e_terc4;
    logic [7:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vdec(input logic [9:0] w);
        logic [7:0] d, r;
        d = w[9] ? ~w[7:0] : w[7:0];
        r = d ^ {d[6:0], 1'b0};
        if (!w[8]) r = r ^ 8'hFE;
        return r;
    endfunction

    // word k of a token stream delayed by dly bits; first word has idle zeros
    function automatic logic [9:0] dword(input logic [9:0] tok, input int dly,
                                         input bit first);
        logic [19:0] t2;
        logic [9:0]  w;
        logic [9:0]  m;
        t2 = {tok, tok};
        t2 = t2 >> (10 - dly);
        w = t2[9:0];
        m = 10'h3FF;
        if (first) w = w & (m << dly);
        return w;
    endfunction

    task automatic cycle(input logic [9:0] w, input logic rst);
        logic [19:0] c;
        logic [9:0]  wn;
        int ci, ti;
        reset = rst;
        tmds_raw = w;
        if (rst) begin
            m_prev = '0; m_locked = 0; m_off = 0; m_tokens = 0; m_misses = 0;
            e_is_ctrl = 0; e_ctrl = 0; e_is_terc4 = 0; e_terc4 = 0;
            e_data = 0; e_de = 0;
        end else begin
            c = {w, m_prev};
            wn = c[m_off +: 10];
            ci = -1;
            ti = -1;
            for (int i = 0; i < 4; i++) if (wn == ctab[i]) ci = i;
            for (int i = 0; i < 16; i++) if (wn == ttab[i]) ti = i;
            e_is_ctrl = (ci >= 0);
            e_ctrl = (ci >= 0) ? 2'(ci) : 2'd0;
            e_is_terc4 = (ti >= 0);
            e_terc4 = (ti >= 0) ? 4'(ti) : 4'd0;
            e_data = vdec(wn);
            if (!m_locked) begin
                if (ci >= 0) begin
                    m_tokens++;
                    if (m_tokens == N_LOCK) begin
                        m_locked = 1; m_tokens = 0; m_misses = 0;
                    end
                end else begin
                    m_tokens = 0;
                    m_off = (m_off + 1) % 10;
                end
            end else if (ci >= 0) begin
                m_misses = 0;
            end else begin
                m_misses++;
                if (m_misses == LOSS_TIMEOUT - 1) begin
                    m_locked = 0; m_tokens = 0; m_misses = 0;
                    m_off = (m_off + 1) % 10;
                end
            end
            e_de = m_locked && !e_is_ctrl;
            m_prev = w;
        end
        @(posedge clk_pixel);
        #1;
        chk("locked", 32'(locked), 32'(m_locked));
        chk("bit_offset", 32'(bit_offset), 32'(m_off));
        chk("is_ctrl", 32'(is_ctrl), 32'(e_is_ctrl));
        chk("ctrl", 32'(ctrl), 32'(e_ctrl));
        chk("is_terc4", 32'(is_terc4), 32'(e_is_terc4));
        chk("terc4", 32'(terc4), 32'(e_terc4));
        chk("data", 32'(data), 32'(e_data));
        chk("de", 32'(de), 32'(e_de));
    endtask

    task automatic run_n(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) cycle(w, 1'b0);
    endtask

    task automatic delayed(input int dly, input int n);
        for (int i = 0; i < n; i++) cycle(dword(TOK0, dly, i == 0), 1'b0);
    endtask

    initial begin
        logic [9:0] rw;
        int sel;

        cycle(10'h2AB, 1'b1);
        cycle(TOK0, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_offset", 32'(bit_offset), 32'd0);
        chk("rst_data", 32'(data), 32'd0);

        // 3-bit delayed token stream locks at offset 3 within 13 cycles
        delayed(3, 13);
        chk("dly3_locked", 32'(locked), 32'd1);
        chk("dly3_offset", 32'(bit_offset), 32'd3);

        // aligned stream locks at offset 0
        cycle(TOK0, 1'b1);
        run_n(TOK0, 25);
        chk("al_locked", 32'(locked), 32'd1);
        chk("al_offset", 32'(bit_offset), 32'd0);
        chk("al_is_ctrl", 32'(is_ctrl), 32'd1);
        chk("al_ctrl", 32'(ctrl), 32'd0);
        chk("al_de", 32'(de), 32'd0);

        cycle(V00, 1'b0);
        cycle(TOK0, 1'b0);
        chk("v00_data", 32'(data), 32'h00);
        chk("v00_de", 32'(de), 32'd1);
        chk("v00_is_ctrl", 32'(is_ctrl), 32'd0);
        cycle(VFE, 1'b0);
        cycle(TOK0, 1'b0);
        chk("vfe_data", 32'(data), 32'hFE);
        cycle(T5, 1'b0);
        cycle(TOK0, 1'b0);
        chk("t5_is_terc4", 32'(is_terc4), 32'd1);
        chk("t5_terc4", 32'(terc4), 32'h5);
        chk("t5_de", 32'(de), 32'd1);
        chk("t5_data", 32'(data), 32'h22);

        // random words, occasional reset, token bursts to regain lock
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3) rw = ctab[$urandom_range(0, 3)];
            else if (sel < 5) rw = ttab[$urandom_range(0, 15)];
            else rw = 10'($urandom);
            if ($urandom_range(0, 99) == 0) cycle(rw, 1'b1);
            else if (sel == 9) run_n(ctab[$urandom_range(0, 3)], 12);
            else cycle(rw, 1'b0);
        end

        // watchdog: token at the limit keeps lock, 4095 misses drops it
        cycle(TOK0, 1'b1);
        run_n(TOK0, 25);
        run_n(V00, 4094);
        cycle(TOK0, 1'b0);
        cycle(TOK0, 1'b0);
        chk("wd_keep", 32'(locked), 32'd1);
        run_n(V00, 4095);
        chk("wd_4094", 32'(locked), 32'd1);
        cycle(V00, 1'b0);
        chk("wd_drop", 32'(locked), 32'd0);
        chk("wd_offset", 32'(bit_offset), 32'd1);

        // reset pulse while locked at offset 7
        cycle(TOK0, 1'b1);
        delayed(7, 25);
        chk("o7_locked", 32'(locked), 32'd1);
        chk("o7_offset", 32'(bit_offset), 32'd7);
        cycle(dword(TOK0, 7, 1'b0), 1'b1);
        chk("rp_locked", 32'(locked), 32'd0);
        chk("rp_offset", 32'(bit_offset), 32'd0);
        chk("rp_is_ctrl", 32'(is_ctrl), 32'd0);
        chk("rp_data", 32'(data), 32'd0);
        for (int i = 0; i < 7; i++) cycle(dword(TOK0, 7, 1'b0), 1'b0);
        chk("rp_nolock", 32'(locked), 32'd0);
        for (int i = 0; i < 20; i++) cycle(dword(TOK0, 7, 1'b0), 1'b0);
        chk("rp_relock", 32'(locked), 32'd1);
        chk("rp_reoff", 32'(bit_offset), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
